// File: rtl/alarm_set_ctrl.sv
// Button-driven time/alarm setter: synchronized, debounced buttons drive
// an hours/minutes BCD edit FSM that strobes the result into Aclock.
module alarm_set_ctrl #(
    parameter int DEBOUNCE = 3,
    parameter int TIMEOUT  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_time,
    input  logic       btn_alarm,
    input  logic       btn_inc,
    input  logic       btn_next,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       editing,
    output logic       field,
    output logic       target
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, COMMIT} state_t;

    // bit order: 0=time 1=alarm 2=inc 3=next
    logic [3:0]    raw, sync1, sync2, acc, acc_d, press;
    logic [CW-1:0] dcnt [4];

    assign raw   = {btn_next, btn_inc, btn_alarm, btn_time};
    assign press = acc & ~acc_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            acc   <= '0;
            acc_d <= '0;
            for (int i = 0; i < 4; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            acc_d <= acc;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == acc[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == CW'(DEBOUNCE - 1)) begin
                    acc[i]  <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + CW'(1);
                end
            end
        end
    end

    state_t        state, state_n;
    logic          target_n;
    logic [1:0]    h1, h1_n;
    logic [3:0]    h0, h0_n, m1, m1_n, m0, m0_n;
    logic [TW-1:0] tcnt, tcnt_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            target <= 1'b0;
            h1     <= '0;
            h0     <= '0;
            m1     <= '0;
            m0     <= '0;
            tcnt   <= '0;
        end else begin
            state  <= state_n;
            target <= target_n;
            h1     <= h1_n;
            h0     <= h0_n;
            m1     <= m1_n;
            m0     <= m0_n;
            tcnt   <= tcnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        target_n = target;
        h1_n     = h1;
        h0_n     = h0;
        m1_n     = m1;
        m0_n     = m0;
        tcnt_n   = tcnt;
        unique case (state)
            IDLE: begin
                tcnt_n = '0;
                if (press[0]) begin
                    state_n  = EDIT_H;
                    target_n = 1'b0;
                end else if (press[1]) begin
                    state_n  = EDIT_H;
                    target_n = 1'b1;
                end
            end
            EDIT_H, EDIT_M: begin
                if (|press) begin
                    tcnt_n = '0;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    state_n = IDLE;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
                if (press[3]) begin
                    state_n = (state == EDIT_H) ? EDIT_M : COMMIT;
                end else if (press[2] && state == EDIT_H) begin
                    if (h1 == 2'd2 && h0 == 4'd3) begin
                        h1_n = '0;
                        h0_n = '0;
                    end else if (h0 == 4'd9) begin
                        h1_n = h1 + 2'd1;
                        h0_n = '0;
                    end else begin
                        h0_n = h0 + 4'd1;
                    end
                end else if (press[2]) begin
                    // minutes wrap at 59 without touching hours
                    if (m0 == 4'd9) begin
                        m0_n = '0;
                        m1_n = (m1 == 4'd5) ? 4'd0 : m1 + 4'd1;
                    end else begin
                        m0_n = m0 + 4'd1;
                    end
                end
            end
            COMMIT: begin
                state_n = IDLE;
                tcnt_n  = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign H_in1    = h1;
    assign H_in0    = h0;
    assign M_in1    = m1;
    assign M_in0    = m0;
    assign LD_time  = (state == COMMIT) && !target;
    assign LD_alarm = (state == COMMIT) && target;
    assign editing  = (state == EDIT_H) || (state == EDIT_M);
    assign field    = (state == EDIT_M);

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Scoreboard bench for alarm_set_ctrl: expected commit strobes are queued
// by the stimulus and checked by a separate monitor on every strobe.
module tb_alarm_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_time = 1'b0;
    logic       btn_alarm = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_next = 1'b0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, editing, field, target;

    int npass = 0;
    int ntotal = 0;

    logic [15:0] exp_q [$];
    logic [13:0] clk_time = '0;
    logic [13:0] clk_alarm = 14'h3fff;

    alarm_set_ctrl #(.DEBOUNCE(3), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset),
        .btn_time(btn_time), .btn_alarm(btn_alarm),
        .btn_inc(btn_inc), .btn_next(btn_next),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm),
        .editing(editing), .field(field), .target(target)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] bcd();
        return {H_in1, H_in0, M_in1, M_in0};
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] req);
        ntotal++;
        if (act === req) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // monitor: every strobe must match the head of the queue
    always @(negedge clk) begin
        if (reset && (LD_time || LD_alarm)) begin
            if (exp_q.size() == 0) begin
                ntotal++;
                $display("FAIL unexpected_strobe: got %h expected none",
                         {LD_alarm, LD_time, bcd()});
            end else begin
                check("strobe", {LD_alarm, LD_time, bcd()}, exp_q.pop_front());
            end
            if (LD_time) clk_time = bcd();
            if (LD_alarm) clk_alarm = bcd();
        end
    end

    task automatic press(input logic [3:0] b);
        @(negedge clk);
        {btn_next, btn_inc, btn_alarm, btn_time} = b;
        repeat (6) @(negedge clk);
        {btn_next, btn_inc, btn_alarm, btn_time} = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) press(4'b0100);
    endtask

    localparam logic [3:0] TIME = 4'b0001;
    localparam logic [3:0] ALRM = 4'b0010;
    localparam logic [3:0] NEXT = 4'b1000;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_bcd", {2'b0, bcd()}, 16'h0000);
        check("reset_flags", {11'b0, LD_time, LD_alarm, editing, field, target},
              16'h0000);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // time edit to 10:19
        press(TIME);
        check("time_enter", {13'b0, editing, field, target}, 16'h0004);
        incs(10);
        check("hours_10", {2'b0, bcd()}, 16'h1000);
        press(NEXT);
        check("field_min", {15'b0, field}, 16'h0001);
        incs(19);
        check("min_19", {2'b0, bcd()}, 16'h1019);
        exp_q.push_back({1'b0, 1'b1, 14'h1019});
        press(NEXT);
        check("after_commit", {15'b0, editing}, 16'h0000);

        // alarm edit with hour and minute wrap
        press(ALRM);
        check("alarm_target", {15'b0, target}, 16'h0001);
        incs(10);
        check("hours_20", {2'b0, bcd()}, 16'h2019);
        incs(3);
        check("hours_23", {2'b0, bcd()}, 16'h2319);
        incs(1);
        check("hours_wrap", {2'b0, bcd()}, 16'h0019);
        press(NEXT);
        incs(40);
        check("min_59", {2'b0, bcd()}, 16'h0059);
        incs(1);
        check("min_wrap", {2'b0, bcd()}, 16'h0000);
        exp_q.push_back({1'b1, 1'b0, 14'h0000});
        press(NEXT);
        check("alarm_loaded", {2'b0, clk_alarm}, 16'h0000);

        // glitches then a minimal 3-cycle press
        press(TIME);
        @(negedge clk) btn_inc = 1'b1;
        @(negedge clk) btn_inc = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch1", {2'b0, bcd()}, 16'h0000);
        @(negedge clk) btn_inc = 1'b1;
        repeat (2) @(negedge clk);
        btn_inc = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch2", {2'b0, bcd()}, 16'h0000);
        @(negedge clk) btn_inc = 1'b1;
        repeat (3) @(negedge clk);
        btn_inc = 1'b0;
        repeat (2) @(negedge clk);
        check("edge5_nochg", {2'b0, bcd()}, 16'h0000);
        @(negedge clk);
        check("edge6_inc", {2'b0, bcd()}, 16'h0100);
        repeat (10) @(negedge clk);
        check("single_inc", {2'b0, bcd()}, 16'h0100);

        // inc+next together: next wins
        press(4'b1100);
        check("incnext", {1'b0, field, bcd()}, 16'h4100);
        exp_q.push_back({1'b0, 1'b1, 14'h0100});
        press(NEXT);

        // time+alarm together, then timeout in EDIT_M
        press(TIME | ALRM);
        check("both_target", {14'b0, editing, target}, 16'h0002);
        press(NEXT);
        incs(1);
        repeat (80) @(negedge clk);
        check("still_edit", {15'b0, editing}, 16'h0001);
        repeat (30) @(negedge clk);
        check("timeout_idle", {15'b0, editing}, 16'h0000);
        check("timeout_hold", {2'b0, bcd()}, 16'h0101);

        // reset mid-edit aborts
        press(ALRM);
        press(NEXT);
        @(negedge clk) reset = 1'b0;
        #1;
        check("rst_abort", {editing, field, bcd()}, 16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // commit 00:00 time to match the stored 00:00 alarm
        press(TIME);
        press(NEXT);
        exp_q.push_back({1'b0, 1'b1, 14'h0000});
        press(NEXT);
        check("alarm_fires", {15'b0, clk_time == clk_alarm}, 16'h0001);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
